// File: rtl/comp_share_precompute_block.sv
//------------------------------------------------------------------------------
// Module      : comp_share_precompute_block
// Description : Two-stage shift-add generator of the odd multiples 1x..15x
//               of an unsigned sample, with delay-matched sample and valid.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module comp_share_precompute_block #(
  parameter int IN_DATA_WIDTH  = 17,
  parameter int OUT_DATA_WIDTH = 21
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_data_vld,
  input  logic [IN_DATA_WIDTH-1:0]  in_data,
  output logic [IN_DATA_WIDTH-1:0]  out_data,
  output logic                      out_data_vld,
  output logic [OUT_DATA_WIDTH-1:0] x1,
  output logic [OUT_DATA_WIDTH-1:0] x3,
  output logic [OUT_DATA_WIDTH-1:0] x5,
  output logic [OUT_DATA_WIDTH-1:0] x7,
  output logic [OUT_DATA_WIDTH-1:0] x9,
  output logic [OUT_DATA_WIDTH-1:0] x11,
  output logic [OUT_DATA_WIDTH-1:0] x13,
  output logic [OUT_DATA_WIDTH-1:0] x15,
  output logic                      busy
);

  localparam int c_PAD_W = OUT_DATA_WIDTH - IN_DATA_WIDTH;

  // Stage-1 single-adder-depth terms
  logic [OUT_DATA_WIDTH-1:0] w_x1, w_x3, w_x5, w_x7, w_x9, w_x15;
  // Stage-2 terms built from stage-1 registers
  logic [OUT_DATA_WIDTH-1:0] w_x11, w_x13;

  logic [OUT_DATA_WIDTH-1:0] r_s1_x1, r_s1_x3, r_s1_x5, r_s1_x7, r_s1_x9, r_s1_x15;
  logic                      r_s1_vld;

  logic [OUT_DATA_WIDTH-1:0] r_x1, r_x3, r_x5, r_x7, r_x9, r_x11, r_x13, r_x15;
  logic [IN_DATA_WIDTH-1:0]  r_out_data;
  logic                      r_out_vld;

  assign w_x1  = {{c_PAD_W{1'b0}}, in_data};
  assign w_x3  = w_x1 + (w_x1 << 1);
  assign w_x5  = w_x1 + (w_x1 << 2);
  assign w_x9  = w_x1 + (w_x1 << 3);
  assign w_x7  = (w_x1 << 3) - w_x1;
  assign w_x15 = (w_x1 << 4) - w_x1;

  assign w_x11 = (r_s1_x1 << 3) + r_s1_x3;
  assign w_x13 = (r_s1_x1 << 3) + r_s1_x5;

  // Data registers only load on valid so bubbles cause no toggling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_x1  <= '0;
      r_s1_x3  <= '0;
      r_s1_x5  <= '0;
      r_s1_x7  <= '0;
      r_s1_x9  <= '0;
      r_s1_x15 <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= in_data_vld;
      if (in_data_vld) begin
        r_s1_x1  <= w_x1;
        r_s1_x3  <= w_x3;
        r_s1_x5  <= w_x5;
        r_s1_x7  <= w_x7;
        r_s1_x9  <= w_x9;
        r_s1_x15 <= w_x15;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x1       <= '0;
      r_x3       <= '0;
      r_x5       <= '0;
      r_x7       <= '0;
      r_x9       <= '0;
      r_x11      <= '0;
      r_x13      <= '0;
      r_x15      <= '0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_x1       <= r_s1_x1;
        r_x3       <= r_s1_x3;
        r_x5       <= r_s1_x5;
        r_x7       <= r_s1_x7;
        r_x9       <= r_s1_x9;
        r_x11      <= w_x11;
        r_x13      <= w_x13;
        r_x15      <= r_s1_x15;
        r_out_data <= r_s1_x1[IN_DATA_WIDTH-1:0];
      end
    end
  end

  assign x1           = r_x1;
  assign x3           = r_x3;
  assign x5           = r_x5;
  assign x7           = r_x7;
  assign x9           = r_x9;
  assign x11          = r_x11;
  assign x13          = r_x13;
  assign x15          = r_x15;
  assign out_data     = r_out_data;
  assign out_data_vld = r_out_vld;
  assign busy         = r_s1_vld | r_out_vld;

endmodule

`default_nettype wire

// File: tb/tb_comp_share_precompute_block.sv
//------------------------------------------------------------------------------
// Module      : tb_comp_share_precompute_block
// Description : Randomized self-checking bench with a queue-based reference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_comp_share_precompute_block;

  logic        clk;
  logic        reset;
  logic        in_data_vld;
  logic [16:0] in_data;
  logic [16:0] out_data;
  logic        out_data_vld;
  logic [20:0] x1, x3, x5, x7, x9, x11, x13, x15;
  logic        busy;

  int n_cmp;
  int n_err;
  int cyc;
  int last;
  int n_acc;
  int n_pulse;
  int q_s[$];
  int q_due[$];

  comp_share_precompute_block #(
    .IN_DATA_WIDTH (17),
    .OUT_DATA_WIDTH(21)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_data_vld (in_data_vld),
    .in_data     (in_data),
    .out_data    (out_data),
    .out_data_vld(out_data_vld),
    .x1          (x1),
    .x3          (x3),
    .x5          (x5),
    .x7          (x7),
    .x9          (x9),
    .x11         (x11),
    .x13         (x13),
    .x15         (x15),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every output must equal k * (most recently emitted sample)
  task automatic check_outputs();
    chk("out_data", 32'(out_data), last);
    chk("x1",  32'(x1),  last * 1);
    chk("x3",  32'(x3),  last * 3);
    chk("x5",  32'(x5),  last * 5);
    chk("x7",  32'(x7),  last * 7);
    chk("x9",  32'(x9),  last * 9);
    chk("x11", 32'(x11), last * 11);
    chk("x13", 32'(x13), last * 13);
    chk("x15", 32'(x15), last * 15);
  endtask

  task automatic step(input logic v, input int d);
    logic exp_vld;
    logic [31:0] dv;
    dv = d;
    @(negedge clk);
    in_data_vld = v;
    in_data     = dv[16:0];
    @(posedge clk);
    cyc++;
    if (v) begin
      q_s.push_back(d);
      q_due.push_back(cyc + 1);
      n_acc++;
    end
    #1;
    exp_vld = (q_due.size() > 0) && (q_due[0] == cyc);
    chk("out_data_vld", 32'(out_data_vld), 32'(exp_vld));
    chk("busy", 32'(busy), 32'(v | exp_vld));
    if (exp_vld) begin
      last = q_s.pop_front();
      void'(q_due.pop_front());
    end
    if (out_data_vld) n_pulse++;
    check_outputs();
  endtask

  initial begin
    int dens;
    n_cmp = 0; n_err = 0; cyc = 0; last = 0; n_acc = 0; n_pulse = 0;
    reset = 1'b0; in_data_vld = 1'b0; in_data = '0;
    #1;
    chk("rst_vld", 32'(out_data_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    check_outputs();
    repeat (2) @(posedge clk);
    cyc += 2;
    @(negedge clk);
    reset = 1'b1;

    // Single sample, valid on the first post-reset edge, then hold
    step(1, 5);
    step(0, 0);
    chk("s_x11", 32'(x11), 55);
    chk("s_x13", 32'(x13), 65);
    repeat (10) step(0, 0);

    // Maximum sample
    step(1, 131071);
    step(0, 0);
    chk("max_x15", 32'(x15), 1966065);
    chk("max_x13", 32'(x13), 1703923);
    chk("max_x11", 32'(x11), 1441781);
    chk("max_x1",  32'(x1),  131071);
    repeat (2) step(0, 0);

    // Back-to-back
    step(1, 1); step(1, 2); step(1, 3); step(1, 0);
    repeat (3) step(0, 0);

    // Bubble with a never-accepted 999 on the data bus
    step(1, 10); step(0, 999);
    chk("bub_x9a", 32'(x9), 90);
    step(1, 20); step(0, 999);
    chk("bub_x9b", 32'(x9), 180);
    repeat (3) step(0, 0);

    // Asynchronous reset while sample 7 sits in stage 1
    @(negedge clk);
    in_data_vld = 1'b1;
    in_data     = 17'd7;
    @(posedge clk);
    cyc++;
    #5;
    reset = 1'b0;
    in_data_vld = 1'b0;
    #1;
    last = 0;
    chk("arst_vld", 32'(out_data_vld), 0);
    chk("arst_busy", 32'(busy), 0);
    check_outputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("inrst_vld", 32'(out_data_vld), 0);
      chk("inrst_busy", 32'(busy), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) step(0, 0);

    // Random soak with varying valid density
    dens = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) dens = $urandom_range(5, 100);
      step(($urandom_range(0, 99) < dens), int'($urandom_range(0, 131071)));
    end
    repeat (3) step(0, 0);

    chk("pulse_count", n_pulse, n_acc);
    chk("queue_empty", q_s.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/comp_share_precompute_block.md
Name: comp_share_precompute_block

Overview:
- Upstream neighbour of the computation-sharing multiplier array.
- Takes each 17-bit input sample and produces the eight odd multiples 1x, 3x, 5x, 7x, 9x, 11x, 13x and 15x with shift-add logic only. These are the shared alphabet consumed by every 4-bit base multiplier block.
- Also forwards the sample and its valid, delay-matched, so the downstream stage sees in_data, in_data_vld and x1..x15 coherent on the same cycle.
- Two-stage pipeline, throughput of one sample per clock; outputs are held stable between samples.

Parameters:
- IN_DATA_WIDTH, 17: sample width, unsigned magnitude.
- OUT_DATA_WIDTH, 21: width of each odd multiple; must be ≥ IN_DATA_WIDTH+4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_data_vld  input  1  sample strobe, one sample per asserted cycle.
- in_data  input  IN_DATA_WIDTH  sample (unsigned).
- out_data  output  IN_DATA_WIDTH  delay-matched copy of the accepted sample.
- out_data_vld  output  1  one-cycle pulse: out_data and x1..x15 updated this cycle.
- x1, x3, x5, x7, x9, x11, x13, x15  output  OUT_DATA_WIDTH each  k*sample, zero-extended.
- busy  output  1  high while any valid sample is in flight in stage 1 or stage 2.

Behaviour:
- Reset (reset low, asynchronous): all pipeline registers, out_data, x1..x15, out_data_vld and busy go to 0 immediately. Samples in flight are discarded, with no partial output.
- Stage 1 captures on clock edge N when in_data_vld=1:
  - s1_x1 = in_data, zero-extended.
  - s1_x3 = x1 + (x1<<1); s1_x5 = x1 + (x1<<2); s1_x9 = x1 + (x1<<3).
  - s1_x7 = (x1<<3) - x1; s1_x15 = (x1<<4) - x1.
  - s1_vld = 1.
- Stage 1, edge with in_data_vld=0: s1_vld <= 0 and the stage-1 data registers hold. No data toggling on bubbles.
- Stage 2 loads on edge N+1 when s1_vld=1:
  - x1, x3, x5, x7, x9, x15 <= stage-1 values.
  - x11 <= (s1_x1<<3) + s1_x3; x13 <= (s1_x1<<3) + s1_x5.
  - out_data <= s1_x1[IN_DATA_WIDTH-1:0].
- Stage 2 asserts out_data_vld <= s1_vld on every edge.
- Latency: sample valid at edge N → x1..x15 and out_data_vld=1 visible after edge N+1, i.e. 2 cycles from presentation to output.
- Hold rule: when s1_vld=0, stage-2 outputs keep their last values indefinitely; out_data_vld is 0.
- Back-to-back: consecutive valid cycles produce consecutive out_data_vld pulses, each output set matching its own sample with no mixing between samples.
- busy = s1_vld | out_data_vld, registered-path derived and glitch-free.
- Arithmetic:
  - All sums are unsigned at OUT_DATA_WIDTH.
  - 15*(2^IN_DATA_WIDTH - 1) < 2^OUT_DATA_WIDTH, so no overflow or truncation is possible at the defaults.
  - Subtractions never underflow because the minuend is at least the subtrahend.
- No multipliers: shifts, adds and subtracts only. At most one adder/subtractor depth per stage.
- Reset deassertion takes effect synchronously at the next clock edge. A valid on the first post-reset edge is accepted normally.

Test Plan:
- Single sample: reset release, in_data=5 with vld for 1 cycle → 2 cycles later out_data_vld=1 for exactly 1 cycle, with x1=5, x3=15, x5=25, x7=35, x9=45, x11=55, x13=65, x15=75 and out_data=5. Values held for the following 10 idle cycles.
- Max value: in_data=131071 → x15=1966065, x13=1703923, x11=1441781, x1=131071. No wrap.
- Back-to-back: samples 1, 2, 3, 0 on 4 consecutive cycles → 4 consecutive vld pulses with x7 = 7, 14, 21, 0 and out_data = 1, 2, 3, 0 in order.
- Bubble pattern: vld 1,0,1 with data 10, 999, 20 → pulses 2 cycles apart showing x9=90 then x9=180. The 999 is never visible on any output.
- Reset mid-flight: present 7 with vld, assert reset low half a cycle later (asynchronously) → all outputs 0 immediately, and no vld pulse ever appears for sample 7. busy=0 throughout reset.
- Random soak: 10k random samples with random vld density → every pulse matches k*sample for all eight outputs plus out_data, in order, and the pulse count equals the accepted-sample count.
